// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, sequencer state codes
// and the Gray-code step decoder used by both sequencer and datapath.
package seq_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  localparam int STEPS = 16;

  localparam logic [4:0] ST_IDLE0 = 5'b00000;
  localparam logic [4:0] ST_HOLD  = 5'b10001;
  localparam logic [4:0] ST_ONE   = 5'b10000;

  // Step index 1..STEPS for a step code, 0 for IDLE0/HOLD/ONE/illegal codes.
  function automatic logic [4:0] gray_step(input logic [4:0] cs);
    case (cs)
      5'b00001: gray_step = 5'd1;
      5'b00011: gray_step = 5'd2;
      5'b00010: gray_step = 5'd3;
      5'b00110: gray_step = 5'd4;
      5'b00111: gray_step = 5'd5;
      5'b00101: gray_step = 5'd6;
      5'b00100: gray_step = 5'd7;
      5'b01100: gray_step = 5'd8;
      5'b01101: gray_step = 5'd9;
      5'b01111: gray_step = 5'd10;
      5'b01110: gray_step = 5'd11;
      5'b01010: gray_step = 5'd12;
      5'b01011: gray_step = 5'd13;
      5'b01001: gray_step = 5'd14;
      5'b01000: gray_step = 5'd15;
      5'b11000: gray_step = 5'd16;
      default:  gray_step = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// One combinational iteration of the long operations:
//   MUL: shift-add, {carry,acc,mplier} >> 1 after conditional add of B.
//   DIV: restoring divide, {rem,quot} << 1 then trial subtract of B.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] acc_i,   // MUL: product high half, DIV: remainder
  input  logic [WIDTH-1:0] aux_i,   // MUL: multiplier/low half, DIV: quotient
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_n_o,
  output logic [WIDTH-1:0] aux_n_o
);

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] trial;
  logic             ge;

  assign msum  = {1'b0, acc_i} + (aux_i[0] ? {1'b0, b_i} : '0);
  assign rsh   = {acc_i, aux_i[WIDTH-1]};
  // Remainder stays below B, so when rsh >= B the difference fits in WIDTH bits.
  assign trial = rsh[WIDTH-1:0] - b_i;
  assign ge    = (rsh >= {1'b0, b_i});

  // Select the slice for the captured operation.
  always_comb begin
    acc_n_o = msum[WIDTH:1];
    aux_n_o = {msum[0], aux_i[WIDTH-1:1]};
    if (op_i == OP_DIV) begin
      acc_n_o = ge ? trial : rsh[WIDTH-1:0];
      aux_n_o = {aux_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/seq_alu_datapath.sv
// Operand/result datapath of the sequential ALU. Follows the sequencer's
// state code: captures operands at start, does ADD/CMP in ONE and one
// MUL/DIV iteration per step, publishes result only at the final edge.
module seq_alu_datapath
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en_i,
  input  logic [1:0]         opcode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [4:0]         cstate_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dz_o
);

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, aux_q;
  logic [2*WIDTH-1:0] result_q;
  logic               dz_q;

  logic [WIDTH-1:0]   acc_n, aux_n;
  logic [WIDTH:0]     add_sum;
  logic [4:0]         step;
  logic               start, is_long, gt, lt;

  assign start   = en_i && ((cstate_i == ST_IDLE0) || (cstate_i == ST_HOLD));
  assign step    = gray_step(cstate_i);
  assign is_long = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  assign gt      = (a_q > b_q);
  assign lt      = (a_q < b_q);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .aux_i   (aux_q),
    .b_i     (b_q),
    .acc_n_o (acc_n),
    .aux_n_o (aux_n)
  );

  // Capture at start, iterate in steps, write result on the op's last edge.
  // Op/state mismatches and illegal codes fall through and hold everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      aux_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else if (start) begin
      op_q  <= opcode_i;
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      aux_q <= a_i;
    end else if ((cstate_i == ST_ONE) && !is_long) begin
      result_q <= (op_q == OP_ADD) ? {{(WIDTH-1){1'b0}}, add_sum}
                                   : {{(2*WIDTH-2){1'b0}}, gt, lt};
      dz_q     <= 1'b0;
    end else if ((step != 5'd0) && is_long) begin
      acc_q <= acc_n;
      aux_q <= aux_n;
      if (step == 5'(STEPS)) begin
        if ((op_q == OP_DIV) && (b_q == '0)) begin
          result_q <= {a_q, {WIDTH{1'b1}}};
          dz_q     <= 1'b1;
        end else begin
          result_q <= {acc_n, aux_n};
          if (op_q == OP_DIV) dz_q <= 1'b0;
        end
      end
    end
  end

  assign result_o = result_q;
  assign dz_o     = dz_q;

endmodule

// File: tb/tb_seq_alu_datapath.sv
// Directed bench: a reference sequencer drives cstate; each operation is
// checked for latency, result/dz stability while busy, and final value.
module tb_seq_alu_datapath;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [1:0]  opcode;
  logic [15:0] a, b;
  logic [4:0]  cstate;
  logic [31:0] result;
  logic        dz;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;
  logic        last_dz  = 1'b0;

  always #5 clk = ~clk;

  seq_alu_datapath #(.WIDTH(16)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en_i     (en),
    .opcode_i (opcode),
    .a_i      (a),
    .b_i      (b),
    .cstate_i (cstate),
    .result_o (result),
    .dz_o     (dz)
  );

  // Reference sequencer
  typedef enum logic [1:0] {T_IDLE, T_ONE, T_STEP, T_HOLD} tst_t;
  tst_t ts;
  int   k;

  function automatic logic [4:0] step_code(input int idx);
    case (idx)
      0:  step_code = 5'b00001;  1:  step_code = 5'b00011;
      2:  step_code = 5'b00010;  3:  step_code = 5'b00110;
      4:  step_code = 5'b00111;  5:  step_code = 5'b00101;
      6:  step_code = 5'b00100;  7:  step_code = 5'b01100;
      8:  step_code = 5'b01101;  9:  step_code = 5'b01111;
      10: step_code = 5'b01110;  11: step_code = 5'b01010;
      12: step_code = 5'b01011;  13: step_code = 5'b01001;
      14: step_code = 5'b01000;  default: step_code = 5'b11000;
    endcase
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ts <= T_IDLE;
      k  <= 0;
    end else begin
      case (ts)
        T_IDLE, T_HOLD:
          if (en) begin
            if (opcode == 2'd0 || opcode == 2'd3) ts <= T_ONE;
            else begin ts <= T_STEP; k <= 0; end
          end
        T_ONE:  ts <= T_HOLD;
        default:
          if (k == 15) ts <= T_HOLD;
          else k <= k + 1;
      endcase
    end
  end

  always_comb begin
    cstate = 5'b00000;
    case (ts)
      T_ONE:   cstate = 5'b10000;
      T_HOLD:  cstate = 5'b10001;
      T_STEP:  cstate = step_code(k);
      default: cstate = 5'b00000;
    endcase
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE0/HOLD; optionally disturb inputs mid-operation.
  task automatic run_op(input logic [1:0] op, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] eres, input logic edz, input int elat,
                        input bit toggle, input string tag);
    int lat;
    @(negedge clk);
    en = 1'b1; opcode = op; a = aa; b = bb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    en = 1'b0;
    while (cstate !== 5'b10001 && lat < 40) begin
      chk(result, last_res, {tag, "_busy_res"});
      chk({31'd0, dz}, {31'd0, last_dz}, {tag, "_busy_dz"});
      @(negedge clk);
      lat++;
      if (toggle && lat == 5) begin a = ~a; b = ~b; en = 1'b1; opcode = 2'd0; end
      if (toggle && lat == 6) en = 1'b0;
    end
    chk(32'(lat), 32'(elat), {tag, "_lat"});
    chk(result, eres, {tag, "_res"});
    chk({31'd0, dz}, {31'd0, edz}, {tag, "_dz"});
    last_res = eres;
    last_dz  = edz;
  endtask

  initial begin
    int cnt;
    nrst = 1'b0; en = 1'b0; opcode = 2'd0; a = '0; b = '0;
    #12;
    chk(result, 32'h0, "reset_res");
    chk({31'd0, dz}, 32'h0, "reset_dz");
    chk({27'd0, cstate}, 32'h0, "reset_idle");
    @(negedge clk);
    nrst = 1'b1;

    run_op(2'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2,  1'b0, "add_carry");
    run_op(2'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17, 1'b0, "mul_max");
    run_op(2'd1, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 17, 1'b0, "mul_zero");
    run_op(2'd2, 16'd1000, 16'd7,    32'h0006_008E, 1'b0, 17, 1'b0, "div_1000_7");
    run_op(2'd2, 16'd5,    16'd9,    32'h0005_0000, 1'b0, 17, 1'b0, "div_5_9");
    run_op(2'd2, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 17, 1'b0, "div_zero");
    run_op(2'd0, 16'h0001, 16'h0001, 32'h0000_0002, 1'b0, 2,  1'b0, "add_after_dz");
    run_op(2'd3, 16'd3,    16'd5,    32'h0000_0001, 1'b0, 2,  1'b0, "cmp_lt");
    run_op(2'd3, 16'd5,    16'd3,    32'h0000_0002, 1'b0, 2,  1'b0, "cmp_gt");
    run_op(2'd3, 16'd7,    16'd7,    32'h0000_0000, 1'b0, 2,  1'b0, "cmp_eq");
    run_op(2'd2, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 17, 1'b0, "div_zero2");

    // Reset in the middle of a MUL clears result and dz
    @(negedge clk);
    en = 1'b1; opcode = 2'd1; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    while (cstate !== 5'b01100 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({27'd0, cstate}, 32'h0000_000C, "reach_s8");
    chk(result, 32'h1234_FFFF, "s8_res_held");
    nrst = 1'b0;
    #1;
    chk(result, 32'h0, "midop_reset_res");
    chk({31'd0, dz}, 32'h0, "midop_reset_dz");
    #1;
    nrst = 1'b1;
    last_res = '0;
    last_dz  = 1'b0;

    run_op(2'd1, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0, 17, 1'b1, "mul_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
